// File: rtl/wpa2_onchip_memory_dp.sv
// True-dual-port scratch RAM for the Nios II data master (s1) and the WPA2 hash engine (s2).
// Byte-lane writes (s1 wins same-byte collisions), old-data reads, 1/2-cycle read pipeline, optional clear engine.
module wpa2_onchip_memory_dp #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 12,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    reset_req,
    input  logic                    clken,
    input  logic [ADDR_WIDTH-1:0]   s1_address,
    input  logic                    s1_chipselect,
    input  logic                    s1_read,
    input  logic                    s1_write,
    input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
    input  logic [DATA_WIDTH-1:0]   s1_writedata,
    output logic [DATA_WIDTH-1:0]   s1_readdata,
    output logic                    s1_readdatavalid,
    output logic                    s1_waitrequest,
    input  logic [ADDR_WIDTH-1:0]   s2_address,
    input  logic                    s2_chipselect,
    input  logic                    s2_read,
    input  logic                    s2_write,
    input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
    input  logic [DATA_WIDTH-1:0]   s2_writedata,
    output logic [DATA_WIDTH-1:0]   s2_readdata,
    output logic                    s2_readdatavalid,
    output logic                    s2_waitrequest,
    output logic                    busy
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int NB    = DATA_WIDTH / 8;

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clear_addr_q, clear_addr_d;
    logic                    clear_we;
    logic                    en;
    logic                    waitreq;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic [ADDR_WIDTH-1:0]   addr   [2];
    logic [NB-1:0]           be     [2];
    logic [DATA_WIDTH-1:0]   wdata  [2];
    logic                    rd_acc [2];
    logic                    wr_acc [2];

    logic [READ_LATENCY-1:0] vld_q  [2];
    logic [DATA_WIDTH-1:0]   dat_q  [2][READ_LATENCY];

    assign en      = clken & ~reset_req;
    assign waitreq = reset | (state_q == ST_CLEAR) | ~en;
    assign busy    = (state_q == ST_CLEAR);

    assign addr[0]   = s1_address;
    assign addr[1]   = s2_address;
    assign be[0]     = s1_byteenable;
    assign be[1]     = s2_byteenable;
    assign wdata[0]  = s1_writedata;
    assign wdata[1]  = s2_writedata;
    // Read+write together is treated as a write with no read beat.
    assign rd_acc[0] = s1_chipselect & s1_read & ~s1_write & ~waitreq;
    assign rd_acc[1] = s2_chipselect & s2_read & ~s2_write & ~waitreq;
    assign wr_acc[0] = s1_chipselect & s1_write & ~waitreq;
    assign wr_acc[1] = s2_chipselect & s2_write & ~waitreq;

    always_comb begin
        state_d      = state_q;
        clear_addr_d = clear_addr_q;
        clear_we     = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                if (en) begin
                    clear_we     = 1'b1;
                    clear_addr_d = clear_addr_q + 1'b1;
                    if (&clear_addr_q) begin
                        state_d = ST_READY;
                    end
                end
            end
            default: state_d = ST_READY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            clear_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            clear_addr_q <= clear_addr_d;
        end
    end

    // s2 lanes are written first so that s1 overrides on a same-byte collision.
    always_ff @(posedge clk) begin
        if (clear_we && !reset) begin
            mem[clear_addr_q] <= '0;
        end
        for (int b = 0; b < NB; b++) begin
            if (wr_acc[1] && be[1][b]) mem[addr[1]][b*8 +: 8] <= wdata[1][b*8 +: 8];
        end
        for (int b = 0; b < NB; b++) begin
            if (wr_acc[0] && be[0][b]) mem[addr[0]][b*8 +: 8] <= wdata[0][b*8 +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int p = 0; p < 2; p++) begin
                vld_q[p] <= '0;
                for (int i = 0; i < READ_LATENCY; i++) dat_q[p][i] <= '0;
            end
        end else if (en) begin
            for (int p = 0; p < 2; p++) begin
                vld_q[p][0] <= rd_acc[p];
                if (rd_acc[p]) dat_q[p][0] <= mem[addr[p]];
                for (int i = 1; i < READ_LATENCY; i++) begin
                    vld_q[p][i] <= vld_q[p][i-1];
                    if (vld_q[p][i-1]) dat_q[p][i] <= dat_q[p][i-1];
                end
            end
        end
    end

    assign s1_readdata      = dat_q[0][READ_LATENCY-1];
    assign s2_readdata      = dat_q[1][READ_LATENCY-1];
    assign s1_readdatavalid = vld_q[0][READ_LATENCY-1] & en & ~reset;
    assign s2_readdatavalid = vld_q[1][READ_LATENCY-1] & en & ~reset;
    assign s1_waitrequest   = waitreq;
    assign s2_waitrequest   = waitreq;

endmodule

// File: tb/tb_wpa2_onchip_memory_dp.sv
// Bench for wpa2_onchip_memory_dp: READ_LATENCY 1 and 2 instances share stimulus and are
// checked every cycle against a word-array reference model with expected-beat queues.
module tb_wpa2_onchip_memory_dp;
    localparam int AW    = 6;
    localparam int DEPTH = 64;

    typedef struct {
        logic [31:0] d;
        int          tgt;
    } beat_t;

    logic        clk;
    logic        reset, reset_req, clken;
    logic [AW-1:0] a1, a2;
    logic        cs1, cs2, rd1, rd2, wr1, wr2;
    logic [3:0]  be1, be2;
    logic [31:0] wd1, wd2;

    logic [31:0] rdat [4];
    logic        rval [4];
    logic        wreq [4];
    logic        bsy  [2];

    int total = 0;
    int bad   = 0;

    logic [31:0] mm [DEPTH];
    beat_t       bq [4][$];
    int          beats [4];
    int          clear_left = DEPTH;
    int          n_en = 0;
    bit          armed = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wpa2_onchip_memory_dp #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) u_l1 (
        .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
        .s1_address(a1), .s1_chipselect(cs1), .s1_read(rd1), .s1_write(wr1),
        .s1_byteenable(be1), .s1_writedata(wd1),
        .s1_readdata(rdat[0]), .s1_readdatavalid(rval[0]), .s1_waitrequest(wreq[0]),
        .s2_address(a2), .s2_chipselect(cs2), .s2_read(rd2), .s2_write(wr2),
        .s2_byteenable(be2), .s2_writedata(wd2),
        .s2_readdata(rdat[1]), .s2_readdatavalid(rval[1]), .s2_waitrequest(wreq[1]),
        .busy(bsy[0]));

    wpa2_onchip_memory_dp #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .READ_LATENCY(2), .CLEAR_ON_RESET(1)) u_l2 (
        .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
        .s1_address(a1), .s1_chipselect(cs1), .s1_read(rd1), .s1_write(wr1),
        .s1_byteenable(be1), .s1_writedata(wd1),
        .s1_readdata(rdat[2]), .s1_readdatavalid(rval[2]), .s1_waitrequest(wreq[2]),
        .s2_address(a2), .s2_chipselect(cs2), .s2_read(rd2), .s2_write(wr2),
        .s2_byteenable(be2), .s2_writedata(wd2),
        .s2_readdata(rdat[3]), .s2_readdatavalid(rval[3]), .s2_waitrequest(wreq[3]),
        .busy(bsy[1]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        cs1 = 0; rd1 = 0; wr1 = 0; be1 = 4'h0; wd1 = '0; a1 = '0;
        cs2 = 0; rd2 = 0; wr2 = 0; be2 = 4'h0; wd2 = '0; a2 = '0;
    endtask

    // One clock: compare outputs mid-cycle, then apply the cycle's effect to the model.
    task automatic cyc();
        logic en, ew, ev;
        int   idx;
        en = clken & ~reset_req;
        @(negedge clk);
        if (armed) begin
            ew = reset | (clear_left > 0) | ~en;
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("busy[rl%0d]", d + 1), {31'b0, bsy[d]}, {31'b0, clear_left > 0});
                for (int p = 0; p < 2; p++) begin
                    idx = d * 2 + p;
                    chk($sformatf("waitreq[rl%0d,s%0d]", d + 1, p + 1), {31'b0, wreq[idx]}, {31'b0, ew});
                    ev = en & ~reset & (bq[idx].size() > 0) && (bq[idx][0].tgt == n_en);
                    chk($sformatf("rvalid[rl%0d,s%0d]", d + 1, p + 1), {31'b0, rval[idx]}, {31'b0, ev});
                    if (ev) begin
                        chk($sformatf("rdata[rl%0d,s%0d]", d + 1, p + 1), rdat[idx], bq[idx][0].d);
                        void'(bq[idx].pop_front());
                        beats[idx]++;
                    end
                end
            end
        end
        if (reset) begin
            armed = 1;
            clear_left = DEPTH;
            for (int i = 0; i < 4; i++) bq[i].delete();
        end else if (en) begin
            if (clear_left > 0) begin
                mm[DEPTH - clear_left] = '0;
                clear_left--;
            end else begin
                for (int d = 0; d < 2; d++) begin
                    if (cs1 && rd1 && !wr1) bq[d*2].push_back('{mm[a1], n_en + d + 1});
                    if (cs2 && rd2 && !wr2) bq[d*2+1].push_back('{mm[a2], n_en + d + 1});
                end
                for (int b = 0; b < 4; b++)
                    if (cs2 && wr2 && be2[b]) mm[a2][b*8 +: 8] = wd2[b*8 +: 8];
                for (int b = 0; b < 4; b++)
                    if (cs1 && wr1 && be1[b]) mm[a1][b*8 +: 8] = wd1[b*8 +: 8];
            end
            n_en++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic count_clear(input string tag);
        int n;
        n = 0;
        while (bsy[0] === 1'b1 && n < 200) begin
            cyc();
            n++;
        end
        chk(tag, n, DEPTH);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        reset = 1; reset_req = 0; clken = 1;
        @(posedge clk); #1;
        cyc();
        for (int i = 0; i < 4; i++) chk($sformatf("rst_rdata[%0d]", i), rdat[i], 32'h0);
        cyc();
        reset = 0;
        count_clear("clear_len_first");

        // Preload a non-zero pattern, reset, and check that the clear engine wipes it.
        for (int i = 0; i < DEPTH; i++) begin
            cs1 = 1; wr1 = 1; be1 = 4'hF; wd1 = 32'hDEADBEEF; a1 = AW'(i);
            cyc();
        end
        idle();
        reset = 1; cyc(); reset = 0;
        count_clear("clear_len_preload");
        for (int i = 0; i < DEPTH; i++) begin
            cs1 = 1; rd1 = 1; a1 = AW'(i);
            cyc();
        end
        idle(); cyc(); cyc(); cyc();

        // Write on s1, read back on s2 in the next cycle.
        cs1 = 1; wr1 = 1; be1 = 4'hF; wd1 = 32'h12345678; a1 = 6'h05; cyc();
        idle(); cs2 = 1; rd2 = 1; a2 = 6'h05; cyc();
        idle(); cyc(); cyc(); cyc();

        // Same-address write collision with partial byte lanes.
        cs1 = 1; wr1 = 1; be1 = 4'b0011; wd1 = 32'hAAAAAAAA; a1 = 6'h10;
        cs2 = 1; wr2 = 1; be2 = 4'b0110; wd2 = 32'h55555555; a2 = 6'h10; cyc();
        idle(); cs1 = 1; rd1 = 1; a1 = 6'h10; cyc();
        idle(); cyc(); cyc(); cyc();
        chk("collision_model", mm[6'h10], 32'h0055AAAA);

        // Cross-port read-during-write returns old data.
        cs1 = 1; wr1 = 1; be1 = 4'hF; wd1 = 32'hCAFEF00D; a1 = 6'h20; cyc();
        idle();
        cs1 = 1; wr1 = 1; be1 = 4'hF; wd1 = 32'h11111111; a1 = 6'h20;
        cs2 = 1; rd2 = 1; a2 = 6'h20; cyc();
        idle(); cs2 = 1; rd2 = 1; a2 = 6'h20; cyc();
        idle(); cyc(); cyc(); cyc();

        // Streaming reads with clken dropped for three cycles mid-stream.
        for (int i = 0; i < 8; i++) begin
            cs2 = 1; wr2 = 1; be2 = 4'hF; wd2 = 32'hA0000000 + i * 32'h01010101; a2 = AW'(i);
            cyc();
        end
        idle(); cyc();
        for (int i = 0; i < 4; i++) beats[i] = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                clken = 0;
                cyc(); cyc(); cyc();
                clken = 1;
            end
            cs1 = 1; rd1 = 1; a1 = AW'(i);
            cyc();
        end
        idle(); cyc(); cyc(); cyc(); cyc();
        chk("stream_beats_rl1", beats[0], 8);
        chk("stream_beats_rl2", beats[2], 8);

        // Reset right after a read is accepted, then reset again mid-clear.
        for (int i = 0; i < 4; i++) beats[i] = 0;
        cs1 = 1; rd1 = 1; a1 = 6'h03; cyc();
        idle(); reset = 1; cyc(); reset = 0;
        chk("flush_beats_rl1", beats[0], 0);
        chk("flush_beats_rl2", beats[2], 0);
        for (int i = 0; i < 7; i++) cyc();
        reset = 1; cyc(); reset = 0;
        count_clear("clear_len_restart");

        // Randomized traffic on both ports with en gaps and occasional resets.
        for (int n = 0; n < 400; n++) begin
            reset     = ($urandom_range(0, 199) == 0);
            clken     = ($urandom_range(0, 7) != 0);
            reset_req = ($urandom_range(0, 15) == 0);
            cs1 = $urandom_range(0, 3) != 0; rd1 = $urandom_range(0, 1) != 0; wr1 = $urandom_range(0, 2) == 0;
            cs2 = $urandom_range(0, 3) != 0; rd2 = $urandom_range(0, 1) != 0; wr2 = $urandom_range(0, 2) == 0;
            a1 = AW'($urandom_range(0, 7)); a2 = AW'($urandom_range(0, 7));
            be1 = 4'($urandom); be2 = 4'($urandom);
            wd1 = $urandom; wd2 = $urandom;
            cyc();
        end
        idle(); reset = 0; clken = 1; reset_req = 0;
        for (int n = 0; n < DEPTH + 8; n++) cyc();
        for (int i = 0; i < 4; i++) chk($sformatf("drain[%0d]", i), bq[i].size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wpa2_onchip_memory_dp.md
# wpa2_onchip_memory_dp

Parametrised true-dual-port on-chip RAM with two independent Avalon-MM slave ports: s1 for the Nios II data master, s2 for the WPA2 hash accelerator. It generalises the single-port on-chip memory with configurable width, depth and read latency, plus readdatavalid/waitrequest handshakes, defined cross-port write collision resolution, and an optional hardware clear engine that zeroes the array after reset. It sits on the system interconnect as a shared scratch buffer for PMK/PTK intermediate data.

## Interface
- DATA_WIDTH, 32: word width; multiple of 8.
- ADDR_WIDTH, 12: word address width; depth = 2**ADDR_WIDTH.
- READ_LATENCY, 1: 1 or 2 cycles from accepted read to readdatavalid.
- CLEAR_ON_RESET, 1: 1 = zero the whole array after every reset.

- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- reset_req  in  1  high = freeze RAM access (no accept, pipeline held).
- clken  in  1  low = freeze RAM access (same effect as reset_req high).
- s1_address / s2_address  in  ADDR_WIDTH  word address.
- s1_chipselect / s2_chipselect  in  1  port select.
- s1_read / s2_read  in  1  read request.
- s1_write / s2_write  in  1  write request.
- s1_byteenable / s2_byteenable  in  DATA_WIDTH/8  byte lanes for writes.
- s1_writedata / s2_writedata  in  DATA_WIDTH  write data.
- s1_readdata / s2_readdata  out  DATA_WIDTH  read data, qualified by readdatavalid.
- s1_readdatavalid / s2_readdatavalid  out  1  one pulse per accepted read.
- s1_waitrequest / s2_waitrequest  out  1  high = request not accepted.
- busy  out  1  clear engine active.

## Operation
- en = clken & ~reset_req. Request on port p = chipselect & (read | write).
- State machine: CLEAR, READY.
  - reset → CLEAR if CLEAR_ON_RESET=1, else READY; clear_addr ← 0.
  - CLEAR: each en cycle, write all-zero word (all byteenables) at clear_addr, clear_addr+1; when clear_addr = DEPTH-1 is written → READY. Exactly DEPTH en-cycles.
  - READY: terminal until next reset.
- waitrequest (both ports) = reset | (state=CLEAR) | ~en. busy = (state=CLEAR).
- Accept on port p = request & ~waitrequest. read and write both high: write only, no read beat.
- Write: bytes with byteenable=1 updated; others unchanged.
- Read: returns array word as it was before any write in the same cycle (old-data for same-port and cross-port read-during-write).
- Write-write collision (same address, same cycle): per byte, s1 wins where both byteenables set; bytes enabled by only one port take that port's data.
- Read pipeline per port: valid/data shift register of READ_LATENCY stages, advanced only when en; readdatavalid = last_valid & en; readdata holds last-stage data (never X after reset).
- Reset: in-flight reads discarded; array contents not reset (cleared only by the clear engine when enabled). Reset mid-CLEAR restarts from address 0.
- No ordering between ports; each port in-order, fully pipelined (one request per cycle).

## Timing
- Reset values: readdata 0, readdatavalid 0, waitrequest 1, busy = CLEAR_ON_RESET.
- First cycle after reset deasserts: waitrequest 0 if CLEAR_ON_RESET=0; else 1 for DEPTH en-cycles, then 0 in the cycle state=READY.
- Read accepted in cycle T (en held high): readdatavalid high in T+READ_LATENCY, for one cycle.
- Write accepted in T: visible to reads accepted in T+1 on either port.
- en low for N cycles: latency stretches by N; no beat lost or duplicated.
- READ_LATENCY=2 adds an output register after the RAM read register (Fmax mode).

## Test plan
- CLEAR_ON_RESET=1, ADDR_WIDTH=4: preload 0xDEADBEEF everywhere, pulse reset → busy/waitrequest high exactly 16 cycles; then reads of all 16 addresses return 0x00000000.
- s1 write 0x12345678 at 0x005, be=4'hF in T; s2 read 0x005 in T+1 → s2_readdatavalid at T+1+READ_LATENCY with 0x12345678; repeat for READ_LATENCY=2.
- Same cycle: s1 write 0xAAAAAAAA be=4'b0011, s2 write 0x55555555 be=4'b0110 to 0x010 (old 0) → readback 0x0055AAAA.
- Same cycle s1 write 0x11111111 to 0x020 (old 0xCAFEF00D), s2 read 0x020 → s2 gets 0xCAFEF00D; next s2 read gets 0x11111111.
- Back-to-back s1 reads of 0..7 with clken low for 3 cycles mid-stream → exactly 8 readdatavalid beats, in order, data correct, waitrequest high while clken low.
- Reset asserted one cycle after read accept → no readdatavalid; reset during CLEAR at clear_addr 7 → clear restarts, full DEPTH cycles again.
